// File: rtl/trap_controller_if.sv
// Commit-point bundle between the pipeline and the machine-mode trap controller.
// i_valid qualifies one committing instruction per cycle; o_busy is the not-ready
// side, and upstream must keep i_valid low while it is high.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            i_exception;
    logic [2:0]      i_funct3;
    logic [11:0]     i_funct12;
    logic [XLEN-1:0] i_pc;
    logic            i_irq;
    logic            i_csrWe;
    logic [XLEN-1:0] i_csrWdata;
    logic [XLEN-1:0] o_csrRdata;
    logic            o_ecall;
    logic            o_mret;
    logic            o_ebreak;
    logic            o_illegal;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirectPc;
    logic            o_flush;
    logic            o_busy;
    logic [0:0]      dbg_state;

    modport master (
        output i_valid, i_exception, i_funct3, i_funct12, i_pc, i_irq, i_csrWe, i_csrWdata,
        input  o_csrRdata, o_ecall, o_mret, o_ebreak, o_illegal, o_redirect, o_redirectPc,
        input  o_flush, o_busy, dbg_state
    );

    modport slave (
        input  i_valid, i_exception, i_funct3, i_funct12, i_pc, i_irq, i_csrWe, i_csrWdata,
        output o_csrRdata, o_ecall, o_mret, o_ebreak, o_illegal, o_redirect, o_redirectPc,
        output o_flush, o_busy, dbg_state
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap controller: SYSTEM decode, external interrupt entry, mret,
// trap CSRs and a registered one-cycle front-end redirect.
module trap_controller #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input logic          i_clk,
    input logic          i_rst_n,
    trap_controller_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TRAP = 1'b1;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    logic [0:0]      state;
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            busy;
    logic            dec_en;
    logic            is_ecall;
    logic            is_ebreak;
    logic            is_mret;
    logic            is_illegal;
    logic            irq_take;
    logic            trap_take;
    logic            mret_take;
    logic            csr_wr;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] csr_rdata;

    always_comb begin
        busy       = (state == S_TRAP);
        dec_en     = bus.i_valid && bus.i_exception && (bus.i_funct3 == 3'b000);
        is_ecall   = dec_en && (bus.i_funct12 == 12'h000);
        is_ebreak  = dec_en && (bus.i_funct12 == 12'h001);
        is_mret    = dec_en && (bus.i_funct12 == 12'h302);
        is_illegal = dec_en && !is_ecall && !is_ebreak && !is_mret;

        // An accepted interrupt pre-empts the instruction, so its decode no longer matters.
        irq_take   = bus.i_irq && mstatus_mie && mie_meie && bus.i_valid && !busy;
        trap_take  = !busy && (irq_take || is_illegal || is_ebreak || is_ecall);
        mret_take  = !busy && is_mret && !irq_take;
        csr_wr     = bus.i_csrWe && !busy && !trap_take && !mret_take;

        trap_cause = '0;
        if (irq_take) begin
            trap_cause[XLEN-1] = 1'b1;
            trap_cause[3:0]    = 4'd11;
        end else if (is_illegal) begin
            trap_cause[3:0] = 4'd2;
        end else if (is_ebreak) begin
            trap_cause[3:0] = 4'd3;
        end else begin
            trap_cause[3:0] = 4'd11;
        end

        trap_base   = mtvec & ~XLEN'(3);
        trap_target = (irq_take && mtvec[0]) ? trap_base + XLEN'(44) : trap_base;
    end

    always_comb begin
        csr_rdata = '0;
        case (bus.i_funct12)
            CSR_MSTATUS: begin
                csr_rdata[3]     = mstatus_mie;
                csr_rdata[7]     = mstatus_mpie;
                csr_rdata[12:11] = 2'b11;
            end
            CSR_MIE:      csr_rdata[11] = mie_meie;
            CSR_MIP:      csr_rdata[11] = bus.i_irq;
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = mepc;
            CSR_MCAUSE:   csr_rdata = mcause;
            default:      csr_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= RESET_MTVEC & ~XLEN'(2);
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trap_take) begin
                        mepc         <= bus.i_pc & ~XLEN'(3);
                        mcause       <= trap_cause;
                        mstatus_mpie <= mstatus_mie;
                        mstatus_mie  <= 1'b0;
                        redirect     <= 1'b1;
                        redirect_pc  <= trap_target;
                        state        <= S_TRAP;
                    end else if (mret_take) begin
                        mstatus_mie  <= mstatus_mpie;
                        mstatus_mpie <= 1'b1;
                        redirect     <= 1'b1;
                        redirect_pc  <= mepc;
                        state        <= S_TRAP;
                    end else begin
                        redirect <= 1'b0;
                        // csr_wr already excludes cycles where a trap or mret is accepted.
                        if (csr_wr) begin
                            case (bus.i_funct12)
                                CSR_MSTATUS: begin
                                    mstatus_mie  <= bus.i_csrWdata[3];
                                    mstatus_mpie <= bus.i_csrWdata[7];
                                end
                                CSR_MIE:      mie_meie <= bus.i_csrWdata[11];
                                CSR_MTVEC:    mtvec    <= bus.i_csrWdata & ~XLEN'(2);
                                CSR_MSCRATCH: mscratch <= bus.i_csrWdata;
                                CSR_MEPC:     mepc     <= bus.i_csrWdata & ~XLEN'(3);
                                CSR_MCAUSE:   mcause   <= bus.i_csrWdata;
                                default:      ;
                            endcase
                        end
                    end
                end
                default: begin
                    redirect <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_csrRdata   = csr_rdata;
    assign bus.o_ecall      = is_ecall;
    assign bus.o_ebreak     = is_ebreak;
    assign bus.o_mret       = is_mret;
    assign bus.o_illegal    = is_illegal;
    assign bus.o_redirect   = redirect;
    assign bus.o_redirectPc = redirect_pc;
    assign bus.o_flush      = redirect;
    assign bus.o_busy       = busy;
    assign bus.dbg_state    = state;
endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap controller for the RV32/RV64 core. It decodes SYSTEM instructions (ecall, ebreak, mret, illegal funct12) and external interrupts, and owns the trap CSRs (mstatus, mie, mip, mtvec, mscratch, mepc, mcause). It produces a registered front-end redirect and flush. It sits beside the main decoder, receives the retiring instruction's PC, and drives the fetch PC mux.

## Interface
- XLEN, 32, datapath/CSR width (32 or 64)
- RESET_MTVEC, 0, mtvec value after reset
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  instruction at the commit point is valid this cycle
- i_exception  in  1  instruction is SYSTEM opcode
- i_funct3  in  3  instruction funct3
- i_funct12  in  12  instruction[31:20]; also the CSR address
- i_pc  in  XLEN  PC of the committing instruction
- i_irq  in  1  level-sensitive machine external interrupt
- i_csrWe  in  1  CSR write strobe from the CSR datapath
- i_csrWdata  in  XLEN  CSR write data, already merged for csrrs/csrrc
- o_csrRdata  out  XLEN  combinational read of CSR i_funct12
- o_ecall, o_mret, o_ebreak, o_illegal  out  1 each  combinational decode flags, gated by i_valid
- o_redirect  out  1  registered one-cycle redirect pulse
- o_redirectPc  out  XLEN  target PC; valid when o_redirect=1
- o_flush  out  1  equals o_redirect; squashes younger instructions
- o_busy  out  1  high in state TRAP; upstream holds i_valid low

## Operation
- Decode applies only when i_valid && i_exception && i_funct3==000:
  - funct12 0x000 is ecall.
  - 0x001 is ebreak.
  - 0x302 is mret.
  - Any other value is illegal.
- funct3!=000 is a CSR instruction: no trap, only CSR access.
- Interrupt pending (irqTake) = i_irq && mstatus.MIE && mie.MEIE && i_valid && !o_busy. It is evaluated at instruction boundaries only.
- Priority: interrupt > illegal > ebreak > ecall > mret. When an interrupt is taken, the instruction is not executed: its decode flags are ignored and mepc=i_pc.
- Trap entry, on the cycle the event is accepted:
  - mepc <= {i_pc[XLEN-1:2],2'b00}
  - mcause <= {1'b1, 11} for an interrupt; 2 for illegal; 3 for ebreak; 11 for ecall
  - MPIE <= MIE, MIE <= 0
  - Target = mtvec base ({mtvec[XLEN-1:2],2'b00}). If mtvec[0]=1 and the trap is an interrupt, target = base + 4*11.
- mret: MIE <= MPIE, MPIE <= 1, target = mepc.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 MPP read 2'b11; all other bits read 0.
  - mie 0x304: bit11 MEIE.
  - mip 0x344: bit11 = i_irq, read-only.
  - mtvec 0x305: bit1 reads 0.
  - mscratch 0x340.
  - mepc 0x341: bits1:0 read 0.
  - mcause 0x342.
  - Unmapped addresses read 0; writes to them are ignored.
- A CSR write in the same cycle as an accepted trap or mret is dropped entirely; the trap updates win.
- FSM states:
  - IDLE to TRAP on an accepted trap or mret.
  - TRAP to IDLE unconditionally after one cycle.
  - o_busy=1 in TRAP; all inputs except reset are ignored in TRAP.

## Timing
- Reset values:
  - All CSRs 0, except mtvec=RESET_MTVEC and MPP=11.
  - State IDLE; o_redirect=0, o_flush=0, o_busy=0, o_redirectPc=0.
- Event accepted at edge T. CSR updates and the o_redirect/o_redirectPc registers take effect after edge T, so they are visible in cycle T+1. o_busy=1 in cycle T+1; IDLE again from T+2.
- o_redirect is exactly one cycle wide. Back-to-back traps are at least two cycles apart.
- CSR writes without a trap take effect after the edge; o_csrRdata shows the new value the next cycle (no bypass).
- Asynchronous reset in TRAP: the FSM returns to IDLE immediately, o_redirect clears, and no redirect is emitted.
- XLEN=64: mcause interrupt bit is bit 63; all address arithmetic wraps modulo 2^XLEN.

## Test plan
- Reset with RESET_MTVEC=0x100, read 0x305 -> o_csrRdata=0x100. Read 0x300 -> 0x1800. o_redirect=0.
- ecall at pc=0x2000, mtvec=0x100 -> next cycle o_redirect=1, o_redirectPc=0x100. mepc=0x2000, mcause=11, o_busy=1 for one cycle.
- Write MIE=1 and MEIE=1, raise i_irq with a valid ecall at pc=0x40, mtvec=0x101 -> interrupt wins. o_redirectPc=0x12C, mcause=0x8000000B, MIE=0, MPIE=1.
- Trap at pc=0x200 followed by mret -> o_redirectPc=0x200, MIE restored to 1, MPIE=1.
- funct12=0x105 (wfi) with funct3=000 -> o_illegal=1, mcause=2. Then a CSR write to 0x341 coincident with a trap -> write dropped, mepc equals trap PC.
- Assert i_rst_n low during TRAP -> o_busy=0 and o_redirect=0 immediately; all CSRs at reset values.
